char_rom_arbiter: RTL and testbench

- Shares the single read port of the character ROM pair between two requesters: the background tile fetcher (BG) and the sprite fetcher (SPR).
- Grants one read per cycle and drives the ROM address. It returns the plane-1/plane-2 bytes to the owning requester after the fixed ROM read latency.
- Sits between the video fetch logic and the ROM/PROM data block.
- Suppresses all traffic while the ROM download is active.

---
 rtl/char_rom_arbiter_pkg.sv | 24 ++
 rtl/char_rom_arbiter_if.sv | 45 ++++
 rtl/char_rom_arbiter_rr_arb2.sv | 40 ++++
 rtl/char_rom_arbiter.sv | 101 ++++++++++
 tb/tb_char_rom_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/char_rom_arbiter_pkg.sv
// Shared video-fetch types: requester owner encoding and the read-return tag
// that travels alongside each character ROM access.
package char_rom_arbiter_pkg;

    typedef enum logic {
        OWN_BG  = 1'b0,
        OWN_SPR = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_BG};

    function automatic tag_t make_tag(input logic valid, input logic spr_won);
        tag_t t;
        t.valid = valid;
        t.owner = spr_won ? OWN_SPR : OWN_BG;
        return t;
    endfunction

endpackage

// File: rtl/char_rom_arbiter_if.sv
// Request/return bus between the BG/SPR fetchers, the character ROM pair and
// the arbiter. The arbiter uses the slave side; fetchers and ROM the master side.
interface char_rom_arbiter_if #(
    parameter int AW = 17
) ();

    logic          ioctl_download;

    logic          bg_req;
    logic [AW-1:0] bg_addr;
    logic          bg_ack;
    logic          bg_valid;
    logic [7:0]    bg_data1;
    logic [7:0]    bg_data2;

    logic          spr_req;
    logic [AW-1:0] spr_addr;
    logic          spr_ack;
    logic          spr_valid;
    logic [7:0]    spr_data1;
    logic [7:0]    spr_data2;

    logic [AW-1:0] char_rom_addr;
    logic [7:0]    char_data1;
    logic [7:0]    char_data2;

    modport master (
        output ioctl_download,
        output bg_req, bg_addr, spr_req, spr_addr,
        output char_data1, char_data2,
        input  bg_ack, bg_valid, bg_data1, bg_data2,
        input  spr_ack, spr_valid, spr_data1, spr_data2,
        input  char_rom_addr
    );

    modport slave (
        input  ioctl_download,
        input  bg_req, bg_addr, spr_req, spr_addr,
        input  char_data1, char_data2,
        output bg_ack, bg_valid, bg_data1, bg_data2,
        output spr_ack, spr_valid, spr_data1, spr_data2,
        output char_rom_addr
    );

endinterface

// File: rtl/char_rom_arbiter_rr_arb2.sv
// Two-input arbiter for BG/SPR: round-robin on ties, or fixed SPR priority.
// The pointer remembers who won last and only moves on an actual grant.
module char_rom_arbiter_rr_arb2 #(
    parameter int SPR_PRIO = 0
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic req_bg,
    input  logic req_spr,
    output logic gnt_bg,
    output logic gnt_spr
);

    logic last_spr;

    always_comb begin
        gnt_bg  = 1'b0;
        gnt_spr = 1'b0;
        if (req_bg && req_spr) begin
            if ((SPR_PRIO != 0) || !last_spr) begin
                gnt_spr = 1'b1;
            end else begin
                gnt_bg = 1'b1;
            end
        end else begin
            gnt_bg  = req_bg;
            gnt_spr = req_spr;
        end
    end

    // Reset as "SPR won last" so the first tie goes to BG.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            last_spr <= 1'b1;
        end else if (gnt_bg || gnt_spr) begin
            last_spr <= gnt_spr;
        end
    end

endmodule

// File: rtl/char_rom_arbiter.sv
// Shares the character ROM read port between the BG and sprite fetchers and
// steers each returned plane-1/plane-2 byte pair back to the requester that owns it.
module char_rom_arbiter
    import char_rom_arbiter_pkg::*;
#(
    parameter int AW       = 17,
    parameter int RD_LAT   = 1,
    parameter int SPR_PRIO = 0
) (
    input  logic              clk_sys,
    input  logic              reset,
    char_rom_arbiter_if.slave bus
);

    localparam int DEPTH = RD_LAT + 1;

    logic          el_bg;
    logic          el_spr;
    logic          gnt_bg;
    logic          gnt_spr;
    logic [AW-1:0] grant_addr;
    tag_t          pipe [DEPTH];
    tag_t          tail;

    // A requester being acked this cycle is retiring its request; don't grant it twice.
    assign el_bg  = bus.bg_req  && !bus.bg_ack  && !bus.ioctl_download;
    assign el_spr = bus.spr_req && !bus.spr_ack && !bus.ioctl_download;

    char_rom_arbiter_rr_arb2 #(
        .SPR_PRIO (SPR_PRIO)
    ) u_arb (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req_bg  (el_bg),
        .req_spr (el_spr),
        .gnt_bg  (gnt_bg),
        .gnt_spr (gnt_spr)
    );

    assign grant_addr = gnt_spr ? bus.spr_addr : bus.bg_addr;
    assign tail       = pipe[DEPTH-1];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.char_rom_addr <= '0;
            bus.bg_ack        <= 1'b0;
            bus.spr_ack       <= 1'b0;
        end else begin
            bus.bg_ack  <= gnt_bg;
            bus.spr_ack <= gnt_spr;
            if (gnt_bg || gnt_spr) begin
                bus.char_rom_addr <= grant_addr;
            end
        end
    end

    // Tag pipeline: a download edge wipes every tag in flight, including
    // the one that would otherwise be captured on this very edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= TAG_NONE;
            end
        end else if (bus.ioctl_download) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= TAG_NONE;
            end
        end else begin
            pipe[0] <= make_tag(gnt_bg || gnt_spr, gnt_spr);
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.bg_valid  <= 1'b0;
            bus.spr_valid <= 1'b0;
            bus.bg_data1  <= 8'h00;
            bus.bg_data2  <= 8'h00;
            bus.spr_data1 <= 8'h00;
            bus.spr_data2 <= 8'h00;
        end else begin
            bus.bg_valid  <= 1'b0;
            bus.spr_valid <= 1'b0;
            if (tail.valid && !bus.ioctl_download) begin
                if (tail.owner == OWN_SPR) begin
                    bus.spr_data1 <= bus.char_data1;
                    bus.spr_data2 <= bus.char_data2;
                    bus.spr_valid <= 1'b1;
                end else begin
                    bus.bg_data1  <= bus.char_data1;
                    bus.bg_data2  <= bus.char_data2;
                    bus.bg_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Scoreboard bench for char_rom_arbiter: three configurations driven side by side,
// each checked cycle by cycle against a queue-based model of the grant/return rules.
module tb_char_rom_arbiter;

    localparam int AW     = 17;
    localparam int N_INST = 3;

    typedef struct {
        logic          owner;
        logic [AW-1:0] addr;
        int            due;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset;
    logic dl;
    int   mode;
    bit   end_check;
    int   errors = 0;
    int   checks = 0;
    int   dl_left;

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] rom1(input logic [AW-1:0] a);
        if (a == 17'h00123) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
    endfunction

    function automatic logic [7:0] rom2(input logic [AW-1:0] a);
        if (a == 17'h00123) return 8'h3C;
        return ~a[7:0] + a[12:5];
    endfunction

    task automatic check(input int inst, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
        end
    endtask

    // md: 0 idle, 1 random, 2 hold high with a fresh address after every ack
    task automatic step_req(input int md, input logic req, input logic ack,
                            input logic [AW-1:0] addr,
                            output logic nreq, output logic [AW-1:0] naddr);
        nreq  = req;
        naddr = addr;
        case (md)
            1: begin
                if (req && !ack) begin
                    if ($urandom_range(0, 15) == 0) nreq = 1'b0;
                end else begin
                    nreq  = ($urandom_range(0, 99) < 60);
                    naddr = AW'($urandom);
                end
            end
            2: begin
                nreq = 1'b1;
                if (!req || ack) naddr = AW'($urandom);
            end
            default: nreq = 1'b0;
        endcase
    endtask

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam int PRI = (g == 1) ? 1 : 0;

        char_rom_arbiter_if #(.AW(AW)) bus ();

        char_rom_arbiter #(
            .AW       (AW),
            .RD_LAT   (LAT),
            .SPR_PRIO (PRI)
        ) dut (
            .clk_sys (clk_sys),
            .reset   (reset),
            .bus     (bus)
        );

        // ROM: data for the address presented LAT cycles earlier; garbage during download
        logic [AW-1:0] hist [3];
        always @(posedge clk_sys) begin
            hist[0] <= bus.char_rom_addr;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
        assign bus.char_data1     = rom1(hist[LAT-1]) ^ (dl ? 8'hFF : 8'h00);
        assign bus.char_data2     = rom2(hist[LAT-1]) ^ (dl ? 8'hFF : 8'h00);
        assign bus.ioctl_download = dl;

        bit shot_done;
        bit phase;
        always @(posedge clk_sys) begin
            logic          nreq;
            logic [AW-1:0] naddr;
            #1;
            if (reset) begin
                bus.bg_req   = 1'b0;
                bus.spr_req  = 1'b0;
                bus.bg_addr  = '0;
                bus.spr_addr = '0;
                shot_done    = 1'b0;
            end else if (mode == 3) begin
                bus.spr_req = 1'b0;
                if (shot_done || (bus.bg_req && bus.bg_ack)) begin
                    bus.bg_req = 1'b0;
                    shot_done  = 1'b1;
                end else begin
                    bus.bg_req  = 1'b1;
                    bus.bg_addr = 17'h00123;
                end
            end else begin
                shot_done = 1'b0;
                phase     = ~phase;
                step_req((mode == 4) ? 2 : mode, bus.bg_req, bus.bg_ack, bus.bg_addr, nreq, naddr);
                bus.bg_req  = nreq;
                bus.bg_addr = naddr;
                if (mode == 4) begin
                    bus.spr_req = phase;
                    if (phase) bus.spr_addr = AW'($urandom);
                end else begin
                    step_req(mode, bus.spr_req, bus.spr_ack, bus.spr_addr, nreq, naddr);
                    bus.spr_req  = nreq;
                    bus.spr_addr = naddr;
                end
            end
        end

        // Reference: at each falling edge check the current cycle, then decide
        // what the next rising edge grants and when its data must come back.
        exp_t          q [$];
        int            e;
        logic          m_bg_ack, m_spr_ack, last_spr;
        logic [AW-1:0] m_addr;
        logic [7:0]    m_bd1, m_bd2, m_sd1, m_sd2;
        bit            ended;

        always @(negedge clk_sys) begin
            exp_t x;
            logic hit, el_b, el_s, win_s;
            if (reset) begin
                check(g, "rst_bg_ack",    32'(bus.bg_ack), 32'd0);
                check(g, "rst_spr_ack",   32'(bus.spr_ack), 32'd0);
                check(g, "rst_bg_valid",  32'(bus.bg_valid), 32'd0);
                check(g, "rst_spr_valid", 32'(bus.spr_valid), 32'd0);
                check(g, "rst_bg_data",   32'({bus.bg_data1, bus.bg_data2}), 32'd0);
                check(g, "rst_spr_data",  32'({bus.spr_data1, bus.spr_data2}), 32'd0);
                check(g, "rst_rom_addr",  32'(bus.char_rom_addr), 32'd0);
                q.delete();
                e         = 0;
                m_bg_ack  = 1'b0;
                m_spr_ack = 1'b0;
                last_spr  = 1'b1;
                m_addr    = '0;
                {m_bd1, m_bd2, m_sd1, m_sd2} = '0;
            end else begin
                e++;
                hit = (q.size() > 0) && (q[0].due == e);
                if (hit) begin
                    x = q.pop_front();
                    if (x.owner) {m_sd1, m_sd2} = {rom1(x.addr), rom2(x.addr)};
                    else         {m_bd1, m_bd2} = {rom1(x.addr), rom2(x.addr)};
                end
                check(g, "bg_ack",    32'(bus.bg_ack), 32'(m_bg_ack));
                check(g, "spr_ack",   32'(bus.spr_ack), 32'(m_spr_ack));
                check(g, "bg_valid",  32'(bus.bg_valid), 32'(hit && !x.owner));
                check(g, "spr_valid", 32'(bus.spr_valid), 32'(hit && x.owner));
                check(g, "bg_data",   32'({bus.bg_data1, bus.bg_data2}), 32'({m_bd1, m_bd2}));
                check(g, "spr_data",  32'({bus.spr_data1, bus.spr_data2}), 32'({m_sd1, m_sd2}));
                check(g, "rom_addr",  32'(bus.char_rom_addr), 32'(m_addr));

                el_b  = bus.bg_req  && !m_bg_ack  && !dl;
                el_s  = bus.spr_req && !m_spr_ack && !dl;
                win_s = el_s && (!el_b || (PRI == 1) || !last_spr);
                if (dl) q.delete();
                m_bg_ack  = el_b && !win_s;
                m_spr_ack = win_s;
                if (el_b || el_s) begin
                    last_spr = win_s;
                    m_addr   = win_s ? bus.spr_addr : bus.bg_addr;
                    q.push_back('{owner: win_s, addr: m_addr, due: e + LAT + 2});
                end
                if (end_check && !ended) begin
                    ended = 1'b1;
                    check(g, "drained", 32'(q.size()), 32'd0);
                end
            end
        end
    end

    task automatic run(input int md, input int n);
        @(posedge clk_sys);
        #3 mode = md;
        repeat (n - 1) @(posedge clk_sys);
    endtask

    initial begin
        reset     = 1'b1;
        dl        = 1'b0;
        mode      = 0;
        end_check = 1'b0;
        dl_left   = 0;
        repeat (3) @(posedge clk_sys);
        #2 reset = 1'b0;

        run(3, 10);
        run(2, 16);
        run(0, 4);
        run(4, 16);
        run(0, 4);

        // download in the middle of back-to-back traffic
        run(2, 6);
        #1 dl = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1 dl = 1'b0;
        repeat (10) @(posedge clk_sys);

        // reset while reads are in flight
        run(2, 6);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #2 reset = 1'b0;
        repeat (12) @(posedge clk_sys);

        run(1, 1);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_sys);
            #1;
            if (dl_left > 0) dl_left--;
            else if ($urandom_range(0, 49) == 0) dl_left = $urandom_range(1, 4);
            dl = (dl_left > 0);
        end

        run(0, 1);
        #1 dl = 1'b0;
        repeat (10) @(posedge clk_sys);
        end_check = 1'b1;
        repeat (3) @(posedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
